// File: rtl/vx_pkg.sv
// Shared types for the vector execute stage: opcodes, branch conditions, FSM states and flag indices.
package vx_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        BR_NONE   = 3'b000,
        BR_ALWAYS = 3'b001,
        BR_EQ     = 3'b010,
        BR_NE     = 3'b011,
        BR_LT     = 3'b100,
        BR_GE     = 3'b101,
        BR_RSV6   = 3'b110,
        BR_RSV7   = 3'b111
    } cond_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int unsigned FLAG_N = 0;
    localparam int unsigned FLAG_Z = 1;

    function automatic logic eval_branch(cond_e c, logic [1:0] nz);
        logic taken;
        taken = 1'b0;
        case (c)
            BR_ALWAYS: taken = 1'b1;
            BR_EQ:     taken = nz[FLAG_Z];
            BR_NE:     taken = !nz[FLAG_Z];
            BR_LT:     taken = nz[FLAG_N];
            BR_GE:     taken = !nz[FLAG_N];
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/vector_execute_unit_if.sv
// Operand/result handshake bundle of the vector execute stage; master drives operations, slave is the unit.
interface vector_execute_unit_if #(
    parameter int unsigned REG_SIZE = 8,
    parameter int unsigned LANES    = 4
);
    logic                             flush;
    logic                             in_valid;
    logic                             in_ready;
    logic [2:0]                       exec_op;
    logic [LANES-1:0]                 lane_en;
    logic                             overwrite_flags;
    logic [2:0]                       br_cond;
    logic [LANES-1:0][REG_SIZE-1:0]   vect1;
    logic [LANES-1:0][REG_SIZE-1:0]   vect2;
    logic                             out_valid;
    logic                             out_ready;
    logic [LANES-1:0][REG_SIZE-1:0]   vect_out;
    logic                             branch_taken;
    logic [1:0]                       flags_nz;

    modport master (
        output flush, in_valid, exec_op, lane_en, overwrite_flags, br_cond, vect1, vect2, out_ready,
        input  in_ready, out_valid, vect_out, branch_taken, flags_nz
    );

    modport slave (
        input  flush, in_valid, exec_op, lane_en, overwrite_flags, br_cond, vect1, vect2, out_ready,
        output in_ready, out_valid, vect_out, branch_taken, flags_nz
    );
endinterface

// File: rtl/vx_lane.sv
// One vector lane: combinational ALU plus a serial shift-add multiplier datapath.
// VX_SATURATE_EN: unsigned saturating ADD/SUB instead of wrap-around.
module vx_lane
    import vx_pkg::*;
#(
    parameter int unsigned REG_SIZE = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic                step_i,
    input  op_e                 op_i,
    input  logic [REG_SIZE-1:0] a_i,
    input  logic [REG_SIZE-1:0] b_i,
    output logic [REG_SIZE-1:0] result_o,
    output logic                neg_o,
    output logic                zero_o
);
    localparam int unsigned SHW = $clog2(REG_SIZE);

    logic [REG_SIZE-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
    logic [REG_SIZE-1:0] acc_step;
`ifdef VX_SATURATE_EN
    logic [REG_SIZE:0]   sum_ext;
`endif

    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start_i) begin
            acc_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
        end else if (step_i) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    // MUL result is the accumulator after the current step, so the final iteration feeds the slot directly
    always_comb begin
        result_o = '0;
`ifdef VX_SATURATE_EN
        sum_ext  = {1'b0, a_i} + {1'b0, b_i};
`endif
        case (op_i)
`ifdef VX_SATURATE_EN
            OP_ADD:  result_o = sum_ext[REG_SIZE] ? '1 : sum_ext[REG_SIZE-1:0];
            OP_SUB:  result_o = (a_i < b_i) ? '0 : a_i - b_i;
`else
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
`endif
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SHL:  result_o = a_i << b_i[SHW-1:0];
            OP_SHR:  result_o = a_i >> b_i[SHW-1:0];
            OP_MUL:  result_o = acc_step;
            default: result_o = '0;
        endcase
        neg_o  = result_o[REG_SIZE-1];
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/vector_execute_unit.sv
// Vector execute stage: lane ALUs, multi-cycle MUL FSM, single output slot, N/Z flags, branch resolve.
// VX_SATURATE_EN selects saturating ADD/SUB inside the lanes.
module vector_execute_unit
    import vx_pkg::*;
#(
    parameter int unsigned REG_SIZE = 8,
    parameter int unsigned LANES    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    vector_execute_unit_if.slave   vx
);
    localparam int unsigned CNTW = $clog2(REG_SIZE);
    localparam logic [CNTW-1:0] LAST = CNTW'(REG_SIZE - 1);

    state_e                         state_q, state_d;
    logic [CNTW-1:0]                cnt_q, cnt_d;
    op_e                            op_q, op_d, op_sel;
    logic [LANES-1:0]               en_q, en_d, en_sel;
    logic                           ovf_q, ovf_d, ovf_sel;
    logic                           brt_q, brt_d, br_now, br_sel;
    logic                           out_valid_q, out_valid_d;
    logic [LANES-1:0][REG_SIZE-1:0] vect_out_q, vect_out_d;
    logic                           branch_q, branch_d;
    logic [1:0]                     flags_q, flags_d;

    logic                           busy, in_ready, accept, is_mul, mul_start, mul_done, load;
    logic [LANES-1:0][REG_SIZE-1:0] lane_res, res_masked;
    logic [LANES-1:0]               lane_neg, lane_zero;
    logic                           n_unit, z_unit;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        vx_lane #(.REG_SIZE(REG_SIZE)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .start_i  (mul_start),
            .step_i   (busy),
            .op_i     (op_sel),
            .a_i      (vx.vect1[g]),
            .b_i      (vx.vect2[g]),
            .result_o (lane_res[g]),
            .neg_o    (lane_neg[g]),
            .zero_o   (lane_zero[g])
        );
    end

    // While BUSY the lanes and slot see the captured MUL context, not the live inputs
    always_comb begin
        busy      = (state_q == ST_BUSY);
        in_ready  = (state_q == ST_IDLE) && (!out_valid_q || vx.out_ready) && !vx.flush;
        accept    = vx.in_valid && in_ready;
        is_mul    = (op_e'(vx.exec_op) == OP_MUL);
        mul_start = accept && is_mul;
        mul_done  = busy && (cnt_q == LAST) && !vx.flush;
        load      = (accept && !is_mul) || mul_done;
        op_sel    = busy ? op_q : op_e'(vx.exec_op);
        en_sel    = busy ? en_q : vx.lane_en;
        ovf_sel   = busy ? ovf_q : vx.overwrite_flags;
        br_now    = eval_branch(cond_e'(vx.br_cond), flags_q);
        br_sel    = busy ? brt_q : br_now;

        for (int unsigned i = 0; i < LANES; i++) begin
            res_masked[i] = en_sel[i] ? lane_res[i] : '0;
        end
        n_unit = |(lane_neg & en_sel);
        z_unit = &(lane_zero | ~en_sel);

        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        en_d    = en_q;
        ovf_d   = ovf_q;
        brt_d   = brt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (mul_start) begin
                    state_d = ST_BUSY;
                    op_d    = OP_MUL;
                    en_d    = vx.lane_en;
                    ovf_d   = vx.overwrite_flags;
                    brt_d   = br_now;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (vx.flush || (cnt_q == LAST)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        out_valid_d = out_valid_q;
        vect_out_d  = vect_out_q;
        branch_d    = branch_q;
        flags_d     = flags_q;
        if (out_valid_q && vx.out_ready) out_valid_d = 1'b0;
        if (load) begin
            out_valid_d = 1'b1;
            vect_out_d  = res_masked;
            branch_d    = br_sel;
            if (ovf_sel) begin
                flags_d[FLAG_N] = n_unit;
                flags_d[FLAG_Z] = z_unit;
            end
        end
        if (vx.flush) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_ADD;
            en_q        <= '0;
            ovf_q       <= 1'b0;
            brt_q       <= 1'b0;
            out_valid_q <= 1'b0;
            vect_out_q  <= '0;
            branch_q    <= 1'b0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            en_q        <= en_d;
            ovf_q       <= ovf_d;
            brt_q       <= brt_d;
            out_valid_q <= out_valid_d;
            vect_out_q  <= vect_out_d;
            branch_q    <= branch_d;
            flags_q     <= flags_d;
        end
    end

    assign vx.in_ready     = in_ready;
    assign vx.out_valid    = out_valid_q;
    assign vx.vect_out     = vect_out_q;
    assign vx.branch_taken = branch_q;
    assign vx.flags_nz     = flags_q;

endmodule

// File: tb/tb_vector_execute_unit.sv
// Scoreboard bench for vector_execute_unit: directed cases plus randomized ops against a behavioural model.
module tb_vector_execute_unit;
    localparam int RS = 8;
    localparam int LN = 4;
    localparam int VW = RS * LN;

    typedef struct {
        logic [VW-1:0] vec;
        logic          br;
        logic [1:0]    nz;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   ready_mode = 1;
    exp_t q[$];
    exp_t last_exp;
    exp_t mon_e;
    logic [1:0] mflags = 2'b00;
    logic [1:0] saved_flags = 2'b00;

    vector_execute_unit_if #(.REG_SIZE(RS), .LANES(LN)) vx ();

    vector_execute_unit #(.REG_SIZE(RS), .LANES(LN)) dut (
        .clk   (clk),
        .reset (reset),
        .vx    (vx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       vx.out_ready = 1'b0;
            1:       vx.out_ready = 1'b1;
            default: vx.out_ready = (($urandom % 4) != 0);
        endcase
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: lane results from plain integer arithmetic on the operation definitions
    function automatic int lane_ref(int op, int a, int b);
        int m;
        m = 1 << RS;
        case (op)
`ifdef VX_SATURATE_EN
            0: return (a + b > m - 1) ? m - 1 : a + b;
            1: return (a < b) ? 0 : a - b;
`else
            0: return (a + b) % m;
            1: return (a - b + m) % m;
`endif
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (a << (b % RS)) % m;
            6: return a >> (b % RS);
            default: return (a * b) % m;
        endcase
    endfunction

    function automatic logic br_ref(int c, logic [1:0] f);
        case (c)
            1: return 1'b1;
            2: return f[1];
            3: return !f[1];
            4: return f[0];
            5: return !f[0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic issue(int op, logic [LN-1:0] en, logic ovf, int cond,
                         logic [VW-1:0] a, logic [VW-1:0] b, output int waits);
        logic got;
        logic n, z;
        int   r;
        exp_t e;
        vx.exec_op         = op[2:0];
        vx.lane_en         = en;
        vx.overwrite_flags = ovf;
        vx.br_cond         = cond[2:0];
        vx.vect1           = a;
        vx.vect2           = b;
        vx.in_valid        = 1'b1;
        waits = 0;
        got   = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (vx.in_ready) got = 1'b1;
            else waits++;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready never high for op %0d", op);
        end else begin
            n = 1'b0;
            z = 1'b1;
            e.vec = '0;
            for (int i = 0; i < LN; i++) begin
                if (en[i]) begin
                    r = lane_ref(op, int'(a[RS*i +: RS]), int'(b[RS*i +: RS]));
                    e.vec[RS*i +: RS] = r[RS-1:0];
                    if (r >= (1 << (RS - 1))) n = 1'b1;
                    if (r != 0) z = 1'b0;
                end
            end
            e.br = br_ref(cond, mflags);
            saved_flags = mflags;
            if (ovf) mflags = {z, n};
            e.nz = mflags;
            last_exp = e;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        vx.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d responses outstanding", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && vx.out_valid && vx.out_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: vect_out %0h with empty scoreboard", vx.vect_out);
            end else begin
                mon_e = q.pop_front();
                check("vect_out", vx.vect_out, mon_e.vec);
                check("branch_taken", vx.branch_taken, mon_e.br);
                check("flags_nz", vx.flags_nz, mon_e.nz);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, lowcnt, cyc;
        logic [VW-1:0] held;
        logic seen;
        reset = 1'b1;
        vx.flush = 1'b0;
        vx.in_valid = 1'b0;
        vx.exec_op = '0;
        vx.lane_en = '0;
        vx.overwrite_flags = 1'b0;
        vx.br_cond = '0;
        vx.vect1 = '0;
        vx.vect2 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", vx.out_valid, 0);
        check("rst_vect_out", vx.vect_out, 0);
        check("rst_branch", vx.branch_taken, 0);
        check("rst_flags", vx.flags_nz, 0);
        check("rst_in_ready", vx.in_ready, 1);
        @(posedge clk);
        #1;

        // ADD with lane-3 wrap; latency 1
        issue(0, 4'hF, 1'b1, 0, 32'hFF030201, 32'h01010101, w);
        @(negedge clk);
        check("add_latency", vx.out_valid, 1);
        drain();

        // SUB to zero, then EQ branch sees the new Z
        issue(1, 4'hF, 1'b1, 2, 32'h05050505, 32'h05050505, w);
        issue(2, 4'hF, 1'b0, 2, 32'h12345678, 32'h0F0F0F0F, w);
        drain();

        // MUL latency and in_ready low window
        issue(7, 4'hF, 1'b1, 1, {8'd255, 8'd16, 8'd7, 8'd3}, {8'd2, 8'd16, 8'd9, 8'd5}, w);
        lowcnt = 0;
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (vx.out_valid) begin
                cyc = k;
                break;
            end
            if (!vx.in_ready) lowcnt++;
        end
        check("mul_busy_cycles", lowcnt, 8);
        check("mul_out_cycle", cyc, 9);
        drain();

        // Back-to-back full throughput
        for (int k = 0; k < 4; k++) begin
            issue(k % 5, 4'hF, 1'b1, 3, $urandom, $urandom, w);
            if (k > 0) check("throughput_wait", w, 0);
        end
        drain();

        // Output stall with a second op pending
        ready_mode = 0;
        @(posedge clk);
        #1;
        issue(4, 4'hF, 1'b1, 0, 32'hA5A5A5A5, 32'h0F0FF0F0, w);
        held = last_exp.vec;
        vx.exec_op = 3'd0;
        vx.lane_en = 4'hF;
        vx.overwrite_flags = 1'b1;
        vx.br_cond = 3'd2;
        vx.vect1 = 32'h01020304;
        vx.vect2 = 32'h10101010;
        vx.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", vx.in_ready, 0);
            check("stall_vect_out", vx.vect_out, held);
        end
        ready_mode = 1;
        issue(0, 4'hF, 1'b1, 2, 32'h01020304, 32'h10101010, w);
        drain();

        // Flush during MUL BUSY cycle 4
        issue(1, 4'hF, 1'b1, 0, 32'h05050505, 32'h05050505, w);
        drain();
        issue(7, 4'hF, 1'b1, 0, 32'h80010203, 32'h01030507, w);
        repeat (3) @(posedge clk);
        #1 vx.flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready_low", vx.in_ready, 0);
        @(posedge clk);
        #1 vx.flush = 1'b0;
        void'(q.pop_back());
        mflags = saved_flags;
        @(negedge clk);
        check("flush_in_ready", vx.in_ready, 1);
        check("flush_out_valid", vx.out_valid, 0);
        check("flush_flags", vx.flags_nz, mflags);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (vx.out_valid) seen = 1'b1;
        end
        check("flush_no_result", seen, 0);
        @(posedge clk);
        #1;

        // Flush drops a stalled slot but keeps its flags
        ready_mode = 0;
        issue(0, 4'hF, 1'b1, 0, 32'h80808080, 32'h00000001, w);
        #1 vx.flush = 1'b1;
        @(posedge clk);
        #1 vx.flush = 1'b0;
        void'(q.pop_back());
        @(negedge clk);
        check("flush_slot_valid", vx.out_valid, 0);
        check("flush_slot_flags", vx.flags_nz, mflags);
        ready_mode = 1;
        @(posedge clk);
        #1;

        // Reset mid-MUL
        issue(0, 4'hF, 1'b1, 1, 32'h80808080, 32'h00000000, w);
        drain();
        issue(7, 4'hF, 1'b1, 0, 32'h03030303, 32'h05050505, w);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rstmid_out_valid", vx.out_valid, 0);
        check("rstmid_vect_out", vx.vect_out, 0);
        check("rstmid_branch", vx.branch_taken, 0);
        check("rstmid_flags", vx.flags_nz, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        mflags = 2'b00;
        @(negedge clk);
        check("rstmid_in_ready", vx.in_ready, 1);
        @(posedge clk);
        #1;

        // All lanes disabled, reserved condition
        issue(0, 4'h0, 1'b1, 6, 32'h80FF7F01, 32'h01010101, w);
        issue(3, 4'h3, 1'b0, 2, 32'h00000000, 32'h00000000, w);
        drain();

        // Randomized traffic with random backpressure
        ready_mode = 2;
        for (int k = 0; k < 300; k++) begin
            logic [VW-1:0] a, b;
            a = $urandom;
            if ($urandom % 4 == 0) a = a & 32'h0303_0303;
            b = ($urandom % 4 == 0) ? a : $urandom;
            issue(int'($urandom % 8), 4'($urandom), 1'($urandom), int'($urandom % 8), a, b, w);
        end
        ready_mode = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
